// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with per-digit blanking gap.
// Optional build macro SEG_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS         = 8,
    parameter int BLANK_CYC      = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_tick,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYC);

    localparam logic [DIGITS-1:0] AN_OFF  =
        (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  =
        (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_nx;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_nx;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_nx;
    logic                  load_frame;

    logic [4*DIGITS-1:0]   sh_data_q;
    logic [DIGITS-1:0]     sh_dp_q;
    logic [4*DIGITS-1:0]   sh_data_nx;
    logic [DIGITS-1:0]     sh_dp_nx;

    logic                  suppress;
    logic [3:0]            cur_nib;
    logic                  cur_dp;

    logic [DIGITS-1:0]     an_on;
    logic [6:0]            seg_on;
    logic                  dp_on;

    logic [DIGITS-1:0]     an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    // Active-high {g..a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        r = 7'b0000000;
        unique case (v)
            4'h0: r = 7'b0111111;
            4'h1: r = 7'b0000110;
            4'h2: r = 7'b1011011;
            4'h3: r = 7'b1001111;
            4'h4: r = 7'b1100110;
            4'h5: r = 7'b1101101;
            4'h6: r = 7'b1111101;
            4'h7: r = 7'b0000111;
            4'h8: r = 7'b1111111;
            4'h9: r = 7'b1101111;
            4'hA: r = 7'b1110111;
            4'hB: r = 7'b1111100;
            4'hC: r = 7'b0111001;
            4'hD: r = 7'b1011110;
            4'hE: r = 7'b1111001;
            4'hF: r = 7'b1110001;
        endcase
        return r;
    endfunction

    // Scan sequencing: count down the gap, then hold a digit until the next tick.
    always_comb begin
        state_nx   = state_q;
        idx_nx     = idx_q;
        cnt_nx     = cnt_q;
        load_frame = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == '0) begin
                    state_nx   = SHOW;
                    load_frame = (idx_q == '0);
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            SHOW: begin
                if (scan_tick) begin
                    state_nx = BLANK;
                    idx_nx   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    cnt_nx   = CNT_LOAD;
                end
            end
        endcase
    end

    // A frame snapshot is taken as digit 0 lights up, so the whole
    // frame shows one coherent value even if the bus moves mid-scan.
    always_comb begin
        sh_data_nx = sh_data_q;
        sh_dp_nx   = sh_dp_q;
        if (load_frame) begin
            sh_data_nx = data_in;
            sh_dp_nx   = dp_in;
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] tail_zero;

    // tail_zero[i]: every digit from i upward is a bare zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        tail_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc
                & (sh_data_nx[4*i +: 4] == 4'h0)
                & ~sh_dp_nx[i];
            tail_zero[i] = acc;
        end
    end

    // Digit 0 is never suppressed so a zero value still shows "0".
    always_comb begin
        suppress = (idx_nx != '0) && tail_zero[idx_nx];
    end
`else
    // All digits are always shown.
    always_comb begin
        suppress = 1'b0;
    end
`endif

    // Select the nibble and decimal point of the digit about to be shown.
    always_comb begin
        cur_nib = sh_data_nx[4*int'(idx_nx) +: 4];
        cur_dp  = sh_dp_nx[idx_nx];
    end

    // Active-high view of the next output, built from next-state values
    // so outputs move on the same edge as the state register.
    always_comb begin
        an_on  = '0;
        seg_on = 7'b0000000;
        dp_on  = 1'b0;
        if ((state_nx == SHOW) && !suppress) begin
            an_on  = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nx;
            seg_on = hex7(cur_nib);
            dp_on  = cur_dp;
        end
    end

    // Board polarity is applied last.
    always_comb begin
        an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
    end

    // FSM, digit index, gap counter and frame shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            idx_q     <= '0;
            cnt_q     <= CNT_LOAD;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
        end else begin
            state_q   <= state_nx;
            idx_q     <= idx_nx;
            cnt_q     <= cnt_nx;
            sh_data_q <= sh_data_nx;
            sh_dp_q   <= sh_dp_nx;
        end
    end

    // Registered display lines; nothing reaches the pins combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= load_frame;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a digit-slot reference model.
// Honours SEG_LZ_SUPPRESS_EN in the model when the macro is defined.
module tb_seg7_scan_driver;

    localparam int ND = 8;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_tick = 1'b0;
    logic [31:0]   data_in = '0;
    logic [7:0]    dp_in = '0;
    logic [7:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_start;

    seg7_scan_driver #(
        .DIGITS(ND),
        .BLANK_CYC(BC),
        .AN_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan_tick(scan_tick),
        .data_in(data_in),
        .dp_in(dp_in),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int n_checks = 0;
    int n_pass   = 0;
    int fs_cnt   = 0;

    // Model: is a digit lit, gap edges left, digit index, frame snapshot.
    bit m_on;
    int m_wait;
    int m_idx;
    int m_val [ND];
    bit m_dp  [ND];
    bit m_fs;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic bit visible(input int i);
`ifdef SEG_LZ_SUPPRESS_EN
        if (i == 0) return 1'b1;
        for (int j = i; j < ND; j++)
            if (m_val[j] != 0 || m_dp[j]) return 1'b1;
        return 1'b0;
`else
        return (i >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_on   = 1'b0;
        m_wait = BC;
        m_idx  = 0;
        m_fs   = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_val[i] = 0;
            m_dp[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        m_fs = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_on) begin
            if (m_wait == 0) begin
                m_on = 1'b1;
                if (m_idx == 0) begin
                    for (int i = 0; i < ND; i++) begin
                        m_val[i] = int'((data_in >> (4*i)) & 32'hF);
                        m_dp[i]  = dp_in[i];
                    end
                    m_fs = 1'b1;
                end
            end else begin
                m_wait--;
            end
        end else if (scan_tick) begin
            m_on   = 1'b0;
            m_idx  = (m_idx + 1) % ND;
            m_wait = BC;
        end
    endtask

    task automatic compare_all();
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        ea = 8'hFF;
        es = 7'h7F;
        ed = 1'b1;
        if (m_on && visible(m_idx)) begin
            ea = ~(8'd1 << m_idx);
            es = ~hex_tab[m_val[m_idx]];
            ed = ~m_dp[m_idx];
        end
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp", 32'(dp), 32'(ed));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic step(input bit tk);
        scan_tick = tk;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int c = 0; c < n; c++) step((c % 20) == 19);
    endtask

    task automatic wait_digit(input int d, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            step((c % 20) == 19);
            if (an == ~(8'd1 << d)) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        model_reset();

        // Reset held low: everything dark.
        rst_n = 1'b0;
        step(0);
        step(1);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_fs", 32'(frame_start), 32'd0);

        // First digit appears after the reset gap.
        rst_n = 1'b1;
        fs_cnt = 0;
        for (int c = 0; c < 5; c++) step(0);
        check("first_an", 32'(an), 32'hFE);
        check("first_seg", 32'(seg), 32'h40);
        for (int c = 0; c < 10; c++) step(0);
        check("first_fs_cnt", 32'(fs_cnt), 32'd1);

        // Steady scan of 76543210 across two frames.
        data_in = 32'h76543210;
        dp_in   = 8'h00;
        run_ticks(20 * ND * 2 + 40);

        // Mid-frame data change only shows in the next frame.
        wait_digit(3, "reach_d3");
        data_in = 32'hFFFFFFFF;
        run_ticks(20 * ND * 2);

        // Tick during the gap is dropped.
        step(1);
        step(0);
        step(1);
        run_ticks(60);

        // Async reset during digit 5.
        data_in = 32'h89ABCDEF;
        dp_in   = 8'hA5;
        wait_digit(5, "reach_d5");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'd1);
        check("async_fs", 32'(frame_start), 32'd0);
        model_reset();
        @(negedge clk);
        step(0);
        step(0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) step(0);
        check("restart_an", 32'(an), 32'hFE);
        run_ticks(20 * ND + 40);

        // Leading-zero pattern.
        data_in = 32'h00000A05;
        dp_in   = 8'h00;
        run_ticks(20 * ND * 2 + 40);

        // Random ticks, data and decimal points.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                data_in = $urandom >> (4 * $urandom_range(0, 8));
                dp_in   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            end
            step($urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
